dvp_frame_gen: RTL and testbench
================================

// Module: dvp_frame_gen
// PURPOSE
//  Synthesisable OV5640-style DVP transmitter. Emits cam_vsync/cam_href/cam_data byte streams
//  (RGB565, high byte first) that the camera capture path consumes, as a camera stand-in.
//  Pattern set includes a bouncing box with ground-truth coordinates, so the ball-finding and
//  servo chain can be exercised and checked without a sensor.
// PARAMETERS
//  H_ACTIVE   800      active pixels per line; multiple of 8, >= 8
//  V_ACTIVE   480      active lines per frame
//  H_BLANK    64       clocks href low after each line's active bytes, >= 1
//  VS_LINES   2        lines with cam_vsync high at frame start, >= 1
//  V_BACK     4        blank lines after vsync, before the first active line
//  V_FRONT    4        blank lines after the last active line
//  BOX_SIZE   32       box edge in pixels, < min(H_ACTIVE, V_ACTIVE)
//  BOX_STEP   4        box move per frame, in pixels, on each axis
//  BOX_COLOR  16'hF800 box colour (RGB565)
// PORTS
//  clk          in   1   byte clock (the cam_pclk the generator drives)
//  rst          in   1   asynchronous reset, active-high
//  enable       in   1   run frames; sampled only in IDLE and at frame end
//  mode         in   2   0 colour bars, 1 gradient, 2 solid, 3 moving box; latched at frame start
//  solid_color  in   16  RGB565 colour for mode 2; latched at frame start
//  cam_vsync    out  1   frame sync, high VS_LINES lines per frame
//  cam_href     out  1   high while active bytes are valid
//  cam_data     out  8   pixel byte; 0 whenever cam_href is low
//  frame_done   out  1   1-cycle pulse on the last clock of V_FRONT
//  box_x        out  10  left edge of the box in the frame now being sent
//  box_y        out  10  top edge of the box in the frame now being sent
// BEHAVIOUR
//  - Reset (async, immediate): all outputs 0, FSM IDLE, counters 0, box 0/0, both directions +.
//  - Line = LT = 2*H_ACTIVE + H_BLANK clocks. Column counter col runs 0..LT-1; line counter
//    runs 0..(lines of the state)-1.
//  - FSM: IDLE -> VSYNC (enable=1) -> VBACK -> ACTIVE -> VFRONT -> VSYNC if enable else IDLE.
//    Each state lasts an exact whole number of lines: VS_LINES, V_BACK (skipped if 0),
//    V_ACTIVE, and V_FRONT (skipped if 0). When enable drops mid-frame, the frame completes.
//  - On entry to VSYNC: mode and solid_color latched. If the latched mode is 3, the box is
//    advanced for this frame; box_x/box_y then hold the new position for the whole frame.
//  - cam_vsync = 1 on every clock of VSYNC.
//  - In ACTIVE: cam_href = 1 for col < 2*H_ACTIVE. The pixel is px = col>>1 and the active
//    line index is y. col[0]=0 sends pixel[15:8] and col[0]=1 sends pixel[7:0].
//  - All outputs are registered. Latency from state/counter to pins is a fixed 1 clock, and
//    href, vsync and data stay mutually aligned.
//  - Pixel by mode:
//    0: bar = px / (H_ACTIVE/8). Values, in order: FFFF, FFE0, 07FF, 07E0, F81F, F800, 001F, 0000.
//    1: {px[4:0], px[5:0], px[4:0]}, which wraps every 32/64 pixels.
//    2: solid_color as latched.
//    3: BOX_COLOR if box_x <= px < box_x+BOX_SIZE and box_y <= y < box_y+BOX_SIZE, else 0000.
//  - Box motion: x += BOX_STEP*dx. If the result would exceed H_ACTIVE-BOX_SIZE, clamp to
//    that limit and set dx=-. If the result would go below 0, clamp to 0 and set dx=+.
//    y behaves the same against V_ACTIVE-BOX_SIZE. Arithmetic uses 11-bit signed, no wrap.
//  - frame_done pulses on the final clock of the frame. If V_FRONT=0, that is the last
//    ACTIVE clock.
//  - mode/solid_color changes mid-frame have no effect until the next VSYNC.
// TESTING
//  Bench parameters: H_ACTIVE=8, V_ACTIVE=4, H_BLANK=4, VS_LINES=1, V_BACK=1, V_FRONT=1,
//  BOX_SIZE=2, BOX_STEP=4. This gives LT=20 and a 140-clock frame.
//  1) enable=1, mode=0 -> vsync high 20 clks, then 20 low. Each active line has 16 href clocks
//     with bytes FF,FF,FF,E0,07,FF,07,E0,F8,1F,F8,00,00,1F,00,00, then 4 clocks of href=0,
//     data=0. frame_done appears every 140 clocks.
//  2) mode=3, consecutive frames -> box_x: 4, 6 (clamped, dx flips), 2, 0, 4. The box_y
//     sequence is 2, 0, 2, 0. Box bytes F8,00 appear only in box pixels.
//  3) Switch mode 0->2 (solid_color=1234) mid-ACTIVE -> the current frame stays bars and the
//     next frame is all 12,34.
//  4) Drop enable mid-ACTIVE -> the frame completes, frame_done pulses once, then IDLE with
//     all outputs 0 and no further vsync.
//  5) Assert rst at frame clock 70 -> outputs 0 on the same edge. After release with
//     enable=1, vsync restarts and the box is back at 0/0 (first mode-3 frame gives 4/2).
//  6) mode=1 -> pixel 5 of every line is bytes 28,A5, i.e. {00101,000101,00101}.

Source files
------------

// File: rtl/dvp_frame_gen.sv
// OV5640-style DVP stand-in: emits vsync/href/RGB565 byte frames (bars, gradient, solid,
// bouncing box) with every pin registered one clock behind the frame FSM and counters.
`timescale 1ns/1ps
module dvp_frame_gen #(
  parameter int          H_ACTIVE  = 800,
  parameter int          V_ACTIVE  = 480,
  parameter int          H_BLANK   = 64,
  parameter int          VS_LINES  = 2,
  parameter int          V_BACK    = 4,
  parameter int          V_FRONT   = 4,
  parameter int          BOX_SIZE  = 32,
  parameter int          BOX_STEP  = 4,
  parameter logic [15:0] BOX_COLOR = 16'hF800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  mode,
  input  logic [15:0] solid_color,
  output logic        cam_vsync,
  output logic        cam_href,
  output logic [7:0]  cam_data,
  output logic        frame_done,
  output logic [9:0]  box_x,
  output logic [9:0]  box_y
);

  localparam int LT    = 2 * H_ACTIVE + H_BLANK;
  localparam int CW    = $clog2(LT);
  localparam int LW    = $clog2(VS_LINES + V_BACK + V_ACTIVE + V_FRONT + 1);
  localparam int BAR_W = H_ACTIVE / 8;
  localparam int BW    = $clog2(BAR_W + 1);

  localparam logic [CW-1:0]     LAST_COL = CW'(LT - 1);
  localparam logic [CW-1:0]     ACT_COLS = CW'(2 * H_ACTIVE);
  localparam logic signed [10:0] STEP_S  = 11'(BOX_STEP);
  localparam logic signed [10:0] X_LIM   = 11'(H_ACTIVE - BOX_SIZE);
  localparam logic signed [10:0] Y_LIM   = 11'(V_ACTIVE - BOX_SIZE);

  typedef enum logic [2:0] {S_IDLE, S_VSYNC, S_VBACK, S_ACTIVE, S_VFRONT} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   col_q, col_d;
  logic [LW-1:0]   line_q, line_d;
  logic [BW-1:0]   bar_cnt_q, bar_cnt_d;
  logic [2:0]      bar_idx_q, bar_idx_d;
  logic [1:0]      mode_q, mode_d;
  logic [15:0]     color_q, color_d;
  logic [9:0]      box_x_q, box_x_d, box_y_q, box_y_d;
  logic            dir_x_q, dir_x_d, dir_y_q, dir_y_d;
  logic            vsync_q, vsync_d, href_q, href_d, done_q, done_d;
  logic [7:0]      data_q, data_d;

  logic [LW-1:0]   last_line;
  logic            line_end, frame_end, in_cols, in_box;
  logic [5:0]      px6;
  logic [10:0]     px11, y11, bx11, by11;
  logic [15:0]     pixel;

  // Returns {new_dir, new_pos}; dir=1 means moving toward 0.
  function automatic logic [10:0] step_axis(input logic [9:0] pos, input logic dir_neg,
                                            input logic signed [10:0] lim);
    logic signed [10:0] n;
    n = dir_neg ? $signed({1'b0, pos}) - STEP_S : $signed({1'b0, pos}) + STEP_S;
    if (n > lim)    return {1'b1, lim[9:0]};
    else if (n[10]) return {1'b0, 10'd0};
    else            return {dir_neg, n[9:0]};
  endfunction

  always_comb begin
    case (state_q)
      S_VSYNC:  last_line = LW'(VS_LINES - 1);
      S_VBACK:  last_line = LW'(V_BACK - 1);
      S_ACTIVE: last_line = LW'(V_ACTIVE - 1);
      default:  last_line = LW'(V_FRONT - 1);
    endcase
  end

  assign line_end  = (col_q == LAST_COL) && (line_q == last_line);
  assign frame_end = line_end && ((state_q == S_VFRONT) ||
                                  ((state_q == S_ACTIVE) && (V_FRONT == 0)));
  assign in_cols   = col_q < ACT_COLS;

  assign px6  = 6'(col_q >> 1);
  assign px11 = 11'(col_q >> 1);
  assign y11  = 11'(line_q);
  assign bx11 = {1'b0, box_x_q};
  assign by11 = {1'b0, box_y_q};
  assign in_box = (px11 >= bx11) && (px11 < bx11 + 11'(BOX_SIZE)) &&
                  (y11 >= by11) && (y11 < by11 + 11'(BOX_SIZE));

  always_comb begin
    pixel = 16'h0000;
    case (mode_q)
      2'd0: begin
        case (bar_idx_q)
          3'd0: pixel = 16'hFFFF;
          3'd1: pixel = 16'hFFE0;
          3'd2: pixel = 16'h07FF;
          3'd3: pixel = 16'h07E0;
          3'd4: pixel = 16'hF81F;
          3'd5: pixel = 16'hF800;
          3'd6: pixel = 16'h001F;
          default: pixel = 16'h0000;
        endcase
      end
      2'd1:    pixel = {px6[4:0], px6, px6[4:0]};
      2'd2:    pixel = color_q;
      default: pixel = in_box ? BOX_COLOR : 16'h0000;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    line_d    = line_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    mode_d    = mode_q;
    color_d   = color_q;
    box_x_d   = box_x_q;
    box_y_d   = box_y_q;
    dir_x_d   = dir_x_q;
    dir_y_d   = dir_y_q;

    if (state_q != S_IDLE) begin
      col_d = col_q + CW'(1);
      if (col_q == LAST_COL) begin
        col_d  = '0;
        line_d = line_q + LW'(1);
        if (line_q == last_line) begin
          line_d = '0;
          case (state_q)
            S_VSYNC:  state_d = (V_BACK > 0) ? S_VBACK : S_ACTIVE;
            S_VBACK:  state_d = S_ACTIVE;
            S_ACTIVE: if (V_FRONT > 0) state_d = S_VFRONT;
            default:  state_d = state_q;
          endcase
        end
      end
    end

    // Bar position advances after each pixel's low byte; cleared every line end.
    if ((state_q == S_ACTIVE) && in_cols && col_q[0]) begin
      if (bar_cnt_q == BW'(BAR_W - 1)) begin
        bar_cnt_d = '0;
        bar_idx_d = bar_idx_q + 3'd1;
      end else begin
        bar_cnt_d = bar_cnt_q + BW'(1);
      end
    end
    if (col_q == LAST_COL) begin
      bar_cnt_d = '0;
      bar_idx_d = '0;
    end

    if ((state_q == S_IDLE) || frame_end) begin
      if (enable) begin
        state_d = S_VSYNC;
        col_d   = '0;
        line_d  = '0;
        mode_d  = mode;
        color_d = solid_color;
        if (mode == 2'd3) begin
          {dir_x_d, box_x_d} = step_axis(box_x_q, dir_x_q, X_LIM);
          {dir_y_d, box_y_d} = step_axis(box_y_q, dir_y_q, Y_LIM);
        end
      end else begin
        state_d = S_IDLE;
        col_d   = '0;
        line_d  = '0;
      end
    end

    vsync_d = (state_q == S_VSYNC);
    href_d  = (state_q == S_ACTIVE) && in_cols;
    data_d  = href_d ? (col_q[0] ? pixel[7:0] : pixel[15:8]) : 8'h00;
    done_d  = frame_end;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      col_q     <= '0;
      line_q    <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      mode_q    <= '0;
      color_q   <= '0;
      box_x_q   <= '0;
      box_y_q   <= '0;
      dir_x_q   <= 1'b0;
      dir_y_q   <= 1'b0;
      vsync_q   <= 1'b0;
      href_q    <= 1'b0;
      data_q    <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      line_q    <= line_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      mode_q    <= mode_d;
      color_q   <= color_d;
      box_x_q   <= box_x_d;
      box_y_q   <= box_y_d;
      dir_x_q   <= dir_x_d;
      dir_y_q   <= dir_y_d;
      vsync_q   <= vsync_d;
      href_q    <= href_d;
      data_q    <= data_d;
      done_q    <= done_d;
    end
  end

  assign cam_vsync  = vsync_q;
  assign cam_href   = href_q;
  assign cam_data   = data_q;
  assign frame_done = done_q;
  assign box_x      = box_x_q;
  assign box_y      = box_y_q;

endmodule

// File: tb/tb_dvp_frame_gen.sv
// Bench for dvp_frame_gen on an 8x4 frame (LT=20, 140-clock frame): expected bytes and box
// positions are queued by the driver; a negedge monitor pops and compares them.
`timescale 1ns/1ps
module tb_dvp_frame_gen;

  localparam int FRAME = 140;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic [1:0]  mode;
  logic [15:0] solid_color;
  logic        cam_vsync, cam_href, frame_done;
  logic [7:0]  cam_data;
  logic [9:0]  box_x, box_y;

  dvp_frame_gen #(
    .H_ACTIVE(8), .V_ACTIVE(4), .H_BLANK(4), .VS_LINES(1), .V_BACK(1), .V_FRONT(1),
    .BOX_SIZE(2), .BOX_STEP(4), .BOX_COLOR(16'hF800)
  ) dut (
    .clk(clk), .rst(rst), .enable(enable), .mode(mode), .solid_color(solid_color),
    .cam_vsync(cam_vsync), .cam_href(cam_href), .cam_data(cam_data),
    .frame_done(frame_done), .box_x(box_x), .box_y(box_y)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cycle  = 0;
  always @(posedge clk) cycle++;

  logic [7:0]  exp_q[$];
  logic [19:0] box_q[$];
  bit          mon_bytes = 1'b1;
  int          vs_rises = 0;
  int          vs_run = 0;
  logic        prev_vs = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void push_frame(input int m, input logic [15:0] color, input int bx,
                                     input int by);
    logic [15:0] bars [8];
    logic [15:0] pix;
    logic [5:0]  p6;
    bars = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0, 16'hF81F, 16'hF800, 16'h001F, 16'h0000};
    for (int y = 0; y < 4; y++) begin
      for (int px = 0; px < 8; px++) begin
        p6 = 6'(px);
        case (m)
          0:       pix = bars[px];
          1:       pix = {p6[4:0], p6, p6[4:0]};
          2:       pix = color;
          default: pix = (px >= bx && px < bx + 2 && y >= by && y < by + 2) ? 16'hF800 : 16'h0000;
        endcase
        exp_q.push_back(pix[15:8]);
        exp_q.push_back(pix[7:0]);
      end
    end
  endfunction

  // Monitor: byte stream, blanking data, vsync run length, box position per frame.
  always @(negedge clk) begin
    if (rst) begin
      vs_run  = 0;
      prev_vs = 1'b0;
    end else begin
      if (cam_href && mon_bytes) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_byte: got %0h expected none (t=%0t)", cam_data, $time);
        end else begin
          check("byte", cam_data, exp_q.pop_front());
        end
      end else if (!cam_href) begin
        check("blank_data", cam_data, 8'h00);
      end
      if (cam_vsync && cam_href) check("vsync_href_overlap", 1, 0);
      if (cam_vsync) begin
        if (!prev_vs) begin
          vs_rises++;
          if (box_q.size() > 0) check("box_xy", {box_x, box_y}, box_q.pop_front());
        end
        vs_run++;
      end else if (prev_vs) begin
        check("vsync_len", vs_run, 20);
        vs_run = 0;
      end
      prev_vs = cam_vsync;
    end
  end

  task automatic wait_done(input int budget, output int cyc);
    bit seen;
    seen = 1'b0;
    cyc = -1;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (frame_done) begin
        seen = 1'b1;
        cyc = cycle;
      end
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL frame_done_timeout: got none expected pulse within %0d clocks", budget);
    end
  endtask

  task automatic wait_vsync(input int budget);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < budget && !seen; n++) begin
      @(negedge clk);
      if (cam_vsync) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      errors++;
      $display("FAIL vsync_timeout: got none expected vsync within %0d clocks", budget);
    end
  endtask

  task automatic check_pins_zero(input string tag);
    check({tag, "_vsync"}, cam_vsync, 0);
    check({tag, "_href"}, cam_href, 0);
    check({tag, "_data"}, cam_data, 0);
    check({tag, "_done"}, frame_done, 0);
  endtask

  initial begin
    int c1, c2, c3, n;
    rst = 1'b1;
    enable = 1'b0;
    mode = 2'd0;
    solid_color = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_pins_zero("reset");
    check("reset_box", {box_x, box_y}, 20'd0);
    rst = 1'b0;

    // Bars, bars (mode switched to solid mid-frame), then solid; enable dropped in frame 3.
    push_frame(0, 16'h0, 0, 0);
    push_frame(0, 16'h0, 0, 0);
    push_frame(2, 16'h1234, 0, 0);
    enable = 1'b1;
    wait_done(300, c1);
    repeat (60) @(negedge clk);
    mode = 2'd2;
    solid_color = 16'h1234;
    wait_done(300, c2);
    check("frame_period_1", c2 - c1, FRAME);
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_done(300, c3);
    check("frame_period_2", c3 - c2, FRAME);
    n = vs_rises;
    repeat (300) @(negedge clk);
    check("idle_no_vsync", vs_rises, n);
    check_pins_zero("idle");
    check("bytes_left_a", exp_q.size(), 0);

    // Bouncing box over five frames.
    box_q.push_back({10'd4, 10'd2});
    box_q.push_back({10'd6, 10'd0});
    box_q.push_back({10'd2, 10'd2});
    box_q.push_back({10'd0, 10'd0});
    box_q.push_back({10'd4, 10'd2});
    push_frame(3, 16'h0, 4, 2);
    push_frame(3, 16'h0, 6, 0);
    push_frame(3, 16'h0, 2, 2);
    push_frame(3, 16'h0, 0, 0);
    push_frame(3, 16'h0, 4, 2);
    mode = 2'd3;
    enable = 1'b1;
    for (int f = 0; f < 4; f++) wait_done(300, c1);
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_done(300, c1);
    repeat (20) @(negedge clk);
    check("bytes_left_b", exp_q.size(), 0);
    check("box_left_b", box_q.size(), 0);

    // Gradient frame.
    push_frame(1, 16'h0, 0, 0);
    mode = 2'd1;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_done(300, c1);
    repeat (20) @(negedge clk);
    check("bytes_left_c", exp_q.size(), 0);

    // Asynchronous reset in mid-frame, then restart with the box back at 0/0.
    mon_bytes = 1'b0;
    mode = 2'd0;
    enable = 1'b1;
    wait_vsync(300);
    repeat (70) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check_pins_zero("async_rst");
    check("async_rst_box", {box_x, box_y}, 20'd0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    mon_bytes = 1'b1;
    box_q.push_back({10'd4, 10'd2});
    push_frame(3, 16'h0, 4, 2);
    mode = 2'd3;
    enable = 1'b1;
    repeat (60) @(negedge clk);
    enable = 1'b0;
    wait_done(300, c1);
    repeat (20) @(negedge clk);
    check("bytes_left_d", exp_q.size(), 0);
    check("box_left_d", box_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
